demux_router: RTL and testbench

- 1-to-4 byte distributor. It is the write-side counterpart of the 4:1 byte selector.
- Takes one valid/ready byte stream with a 2-bit destination select and steers each accepted byte into one of four per-channel FIFOs (A, B, C, D).
- Each channel drains independently through its own valid/ready port.
- Sits between a single producer (e.g. UART RX or keypad decoder) and four consumers.

---
 rtl/demux_router_pkg.sv | 14 +
 rtl/demux_chan_fifo.sv | 62 ++++++
 rtl/demux_router.sv | 103 ++++++++++
 tb/tb_demux_router.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/demux_router_pkg.sv
// rtl/demux_router_pkg.sv - channel select codes and default sizing for the 1-to-4 byte demux router
package demux_router_pkg;

    localparam logic [1:0] SEL_A = 2'b00;
    localparam logic [1:0] SEL_B = 2'b01;
    localparam logic [1:0] SEL_C = 2'b10;
    localparam logic [1:0] SEL_D = 2'b11;

    localparam int DEF_WIDTH = 8;
    localparam int DEF_DEPTH = 4;

    localparam int NUM_CHAN = 4;

endpackage

// File: rtl/demux_chan_fifo.sv
// rtl/demux_chan_fifo.sv - single-channel synchronous first-word-fall-through FIFO with occupancy count
module demux_chan_fifo
    import demux_router_pkg::*;
#(
    parameter int  WIDTH = DEF_WIDTH,
    parameter int  DEPTH = DEF_DEPTH,
    localparam int CW    = $clog2(DEPTH) + 1,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic [CW-1:0]    cnt,
    output logic             full,
    output logic             empty
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (cnt == CW'(DEPTH));
    assign empty   = (cnt == '0);
    assign do_push = push && !full && !reset;
    assign do_pop  = pop && !empty && !reset;

    // Head byte is forced to zero while empty so stale storage never leaks out.
    assign rdata = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: cnt <= cnt;
            endcase
        end
    end

    // Storage has no reset; its contents are only observed through the count.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= wdata;
        end
    end

endmodule

// File: rtl/demux_router.sv
// rtl/demux_router.sv - steers a valid/ready byte stream into four independently drained channel FIFOs
module demux_router
    import demux_router_pkg::*;
#(
    parameter int  WIDTH = DEF_WIDTH,
    parameter int  DEPTH = DEF_DEPTH,
    localparam int CW    = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] in_data,
    input  logic [1:0]       in_sel,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] A,
    output logic [WIDTH-1:0] B,
    output logic [WIDTH-1:0] C,
    output logic [WIDTH-1:0] D,
    output logic             a_valid,
    output logic             b_valid,
    output logic             c_valid,
    output logic             d_valid,
    input  logic             a_ready,
    input  logic             b_ready,
    input  logic             c_ready,
    input  logic             d_ready,
    output logic [CW-1:0]    a_cnt,
    output logic [CW-1:0]    b_cnt,
    output logic [CW-1:0]    c_cnt,
    output logic [CW-1:0]    d_cnt,
    output logic             drop_err
);

    logic [WIDTH-1:0] ch_data [NUM_CHAN];
    logic [CW-1:0]    ch_cnt  [NUM_CHAN];
    logic [NUM_CHAN-1:0] ch_full;
    logic [NUM_CHAN-1:0] ch_empty;
    logic [NUM_CHAN-1:0] ch_push;
    logic [NUM_CHAN-1:0] ch_pop;
    logic [NUM_CHAN-1:0] ch_ready;
    logic                accept;
    logic                stall_q;
    logic [1:0]          sel_q;

    // Only the selected channel's full flag gates acceptance; a same-cycle
    // pop on that channel does not open room, so there is no ready->ready path.
    assign in_ready = !reset && !ch_full[in_sel];
    assign accept   = in_valid && in_ready;

    assign ch_ready = {d_ready, c_ready, b_ready, a_ready};
    assign ch_pop   = ch_ready & ~ch_empty;

    for (genvar i = 0; i < NUM_CHAN; i++) begin : g_chan
        assign ch_push[i] = accept && (in_sel == 2'(i));

        demux_chan_fifo #(
            .WIDTH (WIDTH),
            .DEPTH (DEPTH)
        ) u_fifo (
            .clk   (clk),
            .reset (reset),
            .push  (ch_push[i]),
            .wdata (in_data),
            .pop   (ch_pop[i]),
            .rdata (ch_data[i]),
            .cnt   (ch_cnt[i]),
            .full  (ch_full[i]),
            .empty (ch_empty[i])
        );
    end

    assign A = ch_data[SEL_A];
    assign B = ch_data[SEL_B];
    assign C = ch_data[SEL_C];
    assign D = ch_data[SEL_D];

    assign a_valid = !ch_empty[SEL_A];
    assign b_valid = !ch_empty[SEL_B];
    assign c_valid = !ch_empty[SEL_C];
    assign d_valid = !ch_empty[SEL_D];

    assign a_cnt = ch_cnt[SEL_A];
    assign b_cnt = ch_cnt[SEL_B];
    assign c_cnt = ch_cnt[SEL_C];
    assign d_cnt = ch_cnt[SEL_D];

    // A stalled offer must keep its destination; retargeting it is a producer
    // protocol violation that latches until reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            drop_err <= 1'b0;
            stall_q  <= 1'b0;
            sel_q    <= SEL_A;
        end else begin
            stall_q <= in_valid && !in_ready;
            sel_q   <= in_sel;
            if (in_valid && stall_q && (in_sel != sel_q)) begin
                drop_err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_demux_router.sv
// tb/tb_demux_router.sv - randomized and directed self-checking bench for demux_router against a queue model
module tb_demux_router;

    localparam int WIDTH = 8;
    localparam int DEPTH = 4;
    localparam int CW    = $clog2(DEPTH) + 1;

    typedef logic [WIDTH-1:0] byte_q_t [$];

    logic             clk = 1'b0;
    logic             reset;
    logic [WIDTH-1:0] in_data;
    logic [1:0]       in_sel;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] A, B, C, D;
    logic             a_valid, b_valid, c_valid, d_valid;
    logic             a_ready, b_ready, c_ready, d_ready;
    logic [CW-1:0]    a_cnt, b_cnt, c_cnt, d_cnt;
    logic             drop_err;

    logic [3:0]       rdy;
    logic [WIDTH-1:0] obs_data [4];
    logic [3:0]       obs_valid;
    logic [CW-1:0]    obs_cnt  [4];

    byte_q_t          q [4];
    logic             m_drop;
    logic             m_stall;
    logic [1:0]       m_sel;

    int               n_total = 0;
    int               n_pass  = 0;

    always #5 clk = ~clk;

    assign {d_ready, c_ready, b_ready, a_ready} = rdy;
    assign obs_data  = '{A, B, C, D};
    assign obs_valid = {d_valid, c_valid, b_valid, a_valid};
    assign obs_cnt   = '{a_cnt, b_cnt, c_cnt, d_cnt};

    demux_router #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .in_data  (in_data),
        .in_sel   (in_sel),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .A        (A),
        .B        (B),
        .C        (C),
        .D        (D),
        .a_valid  (a_valid),
        .b_valid  (b_valid),
        .c_valid  (c_valid),
        .d_valid  (d_valid),
        .a_ready  (a_ready),
        .b_ready  (b_ready),
        .c_ready  (c_ready),
        .d_ready  (d_ready),
        .a_cnt    (a_cnt),
        .b_cnt    (b_cnt),
        .c_cnt    (c_cnt),
        .d_cnt    (d_cnt),
        .drop_err (drop_err)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end else begin
            n_pass++;
        end
    endtask

    // Compare every output against the queue model, then advance one clock
    // and apply the accepted push and any pops to the model.
    task automatic cycle();
        logic       exp_ready;
        logic [3:0] do_pop;
        #2;
        exp_ready = !reset && (q[in_sel].size() < DEPTH);
        check("in_ready", 32'(in_ready), 32'(exp_ready));
        for (int ch = 0; ch < 4; ch++) begin
            check($sformatf("valid%0d", ch), 32'(obs_valid[ch]), 32'(q[ch].size() > 0));
            check($sformatf("data%0d", ch), 32'(obs_data[ch]),
                  (q[ch].size() > 0) ? 32'(q[ch][0]) : 32'h0);
            check($sformatf("cnt%0d", ch), 32'(obs_cnt[ch]), 32'(q[ch].size()));
        end
        check("drop_err", 32'(drop_err), 32'(m_drop));
        for (int ch = 0; ch < 4; ch++) begin
            do_pop[ch] = rdy[ch] && (q[ch].size() > 0);
        end
        @(posedge clk);
        if (reset) begin
            for (int ch = 0; ch < 4; ch++) q[ch].delete();
            m_drop  = 1'b0;
            m_stall = 1'b0;
            m_sel   = 2'b00;
        end else begin
            if (in_valid && m_stall && (in_sel != m_sel)) m_drop = 1'b1;
            m_stall = in_valid && !exp_ready;
            m_sel   = in_sel;
            for (int ch = 0; ch < 4; ch++) begin
                if (do_pop[ch]) void'(q[ch].pop_front());
            end
            if (in_valid && exp_ready) q[in_sel].push_back(in_data);
        end
        #1;
    endtask

    task automatic drive(input logic v, input logic [1:0] s, input logic [WIDTH-1:0] d, input logic [3:0] r);
        in_valid = v;
        in_sel   = s;
        in_data  = d;
        rdy      = r;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        drive(1'b0, 2'b00, 8'h00, 4'h0);
        cycle();
        cycle();
        reset = 1'b0;
    endtask

    initial begin
        m_drop  = 1'b0;
        m_stall = 1'b0;
        m_sel   = 2'b00;
        reset   = 1'b1;
        drive(1'b0, 2'b00, 8'h00, 4'h0);
        @(posedge clk);
        #1;
        do_reset();
        check("rst_a_cnt", 32'(a_cnt), 32'd0);
        check("rst_drop", 32'(drop_err), 32'd0);

        // single byte to C with one clock latency
        drive(1'b1, 2'b10, 8'h5A, 4'h0);
        cycle();
        drive(1'b0, 2'b00, 8'h00, 4'h0);
        #2;
        check("tp1_c", 32'(C), 32'h5A);
        check("tp1_c_valid", 32'(c_valid), 32'd1);
        check("tp1_c_cnt", 32'(c_cnt), 32'd1);
        check("tp1_a", 32'(A), 32'd0);
        check("tp1_bd_valid", 32'({a_valid, b_valid, d_valid}), 32'd0);
        rdy = 4'b0100;
        cycle();
        rdy = 4'h0;

        // fill B, refused fifth push, ordered drain
        for (int i = 1; i <= 4; i++) begin
            drive(1'b1, 2'b01, 8'(i), 4'h0);
            cycle();
        end
        drive(1'b1, 2'b01, 8'h05, 4'h0);
        #2;
        check("tp2_b_cnt", 32'(b_cnt), 32'd4);
        check("tp2_full_ready", 32'(in_ready), 32'd0);
        cycle();
        for (int i = 1; i <= 4; i++) begin
            drive(1'b0, 2'b00, 8'h00, 4'b0010);
            #2;
            check("tp2_drain", 32'(B), 32'(i));
            cycle();
        end
        check("tp2_b_valid", 32'(b_valid), 32'd0);
        check("tp2_b_zero", 32'(B), 32'd0);

        // full channel with pop: push refused this cycle, accepted next
        for (int i = 1; i <= 4; i++) begin
            drive(1'b1, 2'b01, 8'(i), 4'h0);
            cycle();
        end
        drive(1'b1, 2'b01, 8'h05, 4'b0010);
        #2;
        check("tp3_ready_full_pop", 32'(in_ready), 32'd0);
        cycle();
        check("tp3_cnt3", 32'(b_cnt), 32'd3);
        drive(1'b1, 2'b01, 8'h05, 4'h0);
        cycle();
        check("tp3_cnt4", 32'(b_cnt), 32'd4);
        for (int i = 0; i < 4; i++) begin
            drive(1'b0, 2'b00, 8'h00, 4'b0010);
            cycle();
        end

        // simultaneous push and pop on A keeps occupancy at 2
        for (int i = 0; i < 2; i++) begin
            drive(1'b1, 2'b00, 8'h10 + 8'(i), 4'h0);
            cycle();
        end
        for (int i = 2; i < 8; i++) begin
            drive(1'b1, 2'b00, 8'h10 + 8'(i), 4'b0001);
            cycle();
            check("tp4_a_cnt", 32'(a_cnt), 32'd2);
        end
        for (int i = 0; i < 2; i++) begin
            drive(1'b0, 2'b00, 8'h00, 4'b0001);
            cycle();
        end

        // one byte into each channel
        drive(1'b1, 2'b00, 8'hA0, 4'h0); cycle();
        drive(1'b1, 2'b01, 8'hB1, 4'h0); cycle();
        drive(1'b1, 2'b10, 8'hC2, 4'h0); cycle();
        drive(1'b1, 2'b11, 8'hD3, 4'h0); cycle();
        drive(1'b0, 2'b00, 8'h00, 4'h0);
        #2;
        check("tp5_vals", {A, B, C, D}, 32'hA0B1C2D3);
        check("tp5_cnts", 32'({a_cnt, b_cnt, c_cnt, d_cnt}), 32'({3'd1, 3'd1, 3'd1, 3'd1}));
        cycle();
        do_reset();

        // stalled offer to full D, then retarget to A
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 2'b11, 8'hE0 + 8'(i), 4'h0);
            cycle();
        end
        drive(1'b1, 2'b11, 8'hEE, 4'h0);
        cycle();
        drive(1'b1, 2'b00, 8'hEE, 4'h0);
        cycle();
        check("tp6_drop_set", 32'(drop_err), 32'd1);
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 2'b00, 8'h00, 4'h0);
            cycle();
        end
        check("tp6_drop_hold", 32'(drop_err), 32'd1);
        do_reset();
        check("tp6_drop_clr", 32'(drop_err), 32'd0);
        check("tp6_cnt_clr", 32'(d_cnt), 32'd0);

        // randomized traffic with occasional resets and retargeted stalls
        for (int n = 0; n < 1500; n++) begin
            logic [1:0] s;
            s = in_sel;
            if (!(in_valid && !in_ready) || ($urandom_range(0, 15) == 0)) begin
                s = 2'($urandom_range(0, 3));
            end
            reset = ($urandom_range(0, 99) == 0);
            drive(($urandom_range(0, 3) != 0), s, 8'($urandom), 4'($urandom) & 4'($urandom));
            cycle();
        end
        reset = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
